dbg_cap_ctrl_mc: RTL

Multi-channel, parametrised capture controller for the debug path. It replaces the fixed two-RAM, single-ADC-word capture core. Samples from CH_NUM ADC channels are written into a circular capture RAM of depth capture_max_addr+1. It evaluates a per-channel masked pattern or edge trigger with AND/OR combining, honours a pre-trigger window, and reports the trigger address, read start address and done status to the register block. It sits between the ADC capture source and the dual-port debug RAM, in the write-clock domain.

---
 rtl/dbg_cap_ctrl_mc_if.sv | 49 ++++
 rtl/dbg_cap_ctrl_mc.sv | 198 +++++++++++++++++++
 2 files changed

// File: rtl/dbg_cap_ctrl_mc_if.sv
// Signal bundle between the ADC capture source / register block and the capture controller.
// The controller side uses the slave modport; the source / register side uses master.
interface dbg_cap_ctrl_mc_if #(
    parameter int CH_NUM         = 2,
    parameter int ADC_DATA_WIDTH = 16,
    parameter int ADDR_WIDTH     = 12,
    parameter int CNT_WIDTH      = 8
);
    localparam int DW = CH_NUM * ADC_DATA_WIDTH;

    logic [DW-1:0]         adc_data;
    logic                  adc_data_vld;
    logic                  capture_enable;
    logic                  capture_start;
    logic [1:0]            capture_mode;
    logic [ADDR_WIDTH-1:0] capture_max_addr;
    logic [ADDR_WIDTH-1:0] pre_trigger_num;
    logic [DW-1:0]         trigger_pattern;
    logic [DW-1:0]         trigger_mask;
    logic [CH_NUM-1:0]     trigger_ch_en;
    logic                  trigger_logic;
    logic                  tri_succeed_cnt_clr;
    logic                  tri_succeed_cnt_overflow_mode;
    logic                  ram_wr_en;
    logic [ADDR_WIDTH-1:0] ram_waddr;
    logic [DW-1:0]         ram_wdata;
    logic                  tri_succeed;
    logic [ADDR_WIDTH-1:0] tri_addr;
    logic [ADDR_WIDTH-1:0] read_start_addr;
    logic                  capture_busy;
    logic                  capture_done;
    logic [CNT_WIDTH-1:0]  tri_succeed_cnt;

    modport master (
        output adc_data, adc_data_vld, capture_enable, capture_start, capture_mode,
               capture_max_addr, pre_trigger_num, trigger_pattern, trigger_mask,
               trigger_ch_en, trigger_logic, tri_succeed_cnt_clr, tri_succeed_cnt_overflow_mode,
        input  ram_wr_en, ram_waddr, ram_wdata, tri_succeed, tri_addr, read_start_addr,
               capture_busy, capture_done, tri_succeed_cnt
    );

    modport slave (
        input  adc_data, adc_data_vld, capture_enable, capture_start, capture_mode,
               capture_max_addr, pre_trigger_num, trigger_pattern, trigger_mask,
               trigger_ch_en, trigger_logic, tri_succeed_cnt_clr, tri_succeed_cnt_overflow_mode,
        output ram_wr_en, ram_waddr, ram_wdata, tri_succeed, tri_addr, read_start_addr,
               capture_busy, capture_done, tri_succeed_cnt
    );
endinterface

// File: rtl/dbg_cap_ctrl_mc.sv
// Multi-channel capture controller: circular RAM writes with a pre-trigger window,
// masked level/edge triggering combined across channels, and a trigger-success counter.
module dbg_cap_ctrl_mc #(
    parameter int CH_NUM         = 2,
    parameter int ADC_DATA_WIDTH = 16,
    parameter int ADDR_WIDTH     = 12,
    parameter int CNT_WIDTH      = 8
) (
    input  logic             wr_clk,
    input  logic             wr_rst_n,
    dbg_cap_ctrl_mc_if.slave bus
);
    localparam int W  = ADC_DATA_WIDTH;
    localparam int DW = CH_NUM * W;
    localparam logic [ADDR_WIDTH-1:0] ONE_A = ADDR_WIDTH'(1);
    localparam logic [CNT_WIDTH-1:0]  ONE_C = CNT_WIDTH'(1);

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_PRE   = 3'd1,
        ST_ARMED = 3'd2,
        ST_POST  = 3'd3,
        ST_DONE  = 3'd4
    } state_t;

    state_t state_q, state_d;

    logic [ADDR_WIDTH-1:0] waddr_q, waddr_d;
    logic [ADDR_WIDTH-1:0] pre_cnt_q, pre_cnt_d;
    logic [ADDR_WIDTH-1:0] post_rem_q, post_rem_d;
    logic [ADDR_WIDTH-1:0] max_addr_q, max_addr_d;
    logic [ADDR_WIDTH-1:0] pre_eff_q, pre_eff_d;
    logic [1:0]            mode_q, mode_d;
    logic [CH_NUM-1:0]     prev_match_q, prev_match_d;
    logic                  ram_wr_en_q, ram_wr_en_d;
    logic [ADDR_WIDTH-1:0] ram_waddr_q, ram_waddr_d;
    logic [DW-1:0]         ram_wdata_q, ram_wdata_d;
    logic                  tri_succeed_q, tri_succeed_d;
    logic [ADDR_WIDTH-1:0] tri_addr_q, tri_addr_d;
    logic [ADDR_WIDTH-1:0] read_start_q, read_start_d;
    logic [CNT_WIDTH-1:0]  cnt_q, cnt_d;

    logic [CH_NUM-1:0]     ch_match, ch_hit;
    logic                  trig_any, start_ok, sample_ok, fire, pre_last, post_last;
    logic                  capture_busy, capture_done;
    logic [ADDR_WIDTH-1:0] pre_eff_new, post_rem_new, pre_cnt_inc, read_start_new;

    generate
        for (genvar gi = 0; gi < CH_NUM; gi++) begin : g_ch
            assign ch_match[gi] = ((bus.adc_data[gi*W +: W] ^ bus.trigger_pattern[gi*W +: W])
                                   & bus.trigger_mask[gi*W +: W]) == '0;
            assign ch_hit[gi]   = (mode_q == 2'd2) ? (ch_match[gi] & ~prev_match_q[gi])
                                                   : ch_match[gi];
        end
    endgenerate

    // With no channel enabled only immediate mode may trigger; the AND reduction would
    // otherwise fire on every sample.
    always_comb begin
        trig_any = 1'b0;
        if (mode_q == 2'd0)                 trig_any = 1'b1;
        else if (bus.trigger_ch_en == '0)   trig_any = 1'b0;
        else if (bus.trigger_logic)         trig_any = |(ch_hit & bus.trigger_ch_en);
        else                                trig_any = &(ch_hit | ~bus.trigger_ch_en);
    end

    assign start_ok     = bus.capture_enable && bus.capture_start &&
                          (state_q == ST_IDLE || state_q == ST_DONE);
    assign sample_ok    = capture_busy && bus.capture_enable && bus.adc_data_vld;
    assign fire         = (state_q == ST_ARMED) && sample_ok && trig_any;
    assign pre_eff_new  = (bus.pre_trigger_num < bus.capture_max_addr) ? bus.pre_trigger_num
                                                                        : bus.capture_max_addr;
    assign post_rem_new = max_addr_q - pre_eff_q;
    assign pre_cnt_inc  = pre_cnt_q + ONE_A;
    assign pre_last     = (state_q == ST_PRE) && sample_ok && (pre_cnt_inc == pre_eff_q);
    assign post_last    = (state_q == ST_POST) && sample_ok && (post_rem_q == ONE_A);
    // Window start wraps modulo the ring depth max_addr+1, not modulo 2^ADDR_WIDTH.
    assign read_start_new = (waddr_q >= pre_eff_q) ? (waddr_q - pre_eff_q)
                                                   : (waddr_q + post_rem_new + ONE_A);

    always_ff @(posedge wr_clk) begin
        if (!wr_rst_n) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        if (!bus.capture_enable) begin
            state_d = ST_IDLE;
        end else begin
            case (state_q)
                ST_IDLE, ST_DONE: if (bus.capture_start)
                                      state_d = (pre_eff_new != '0) ? ST_PRE : ST_ARMED;
                ST_PRE:           if (pre_last) state_d = ST_ARMED;
                ST_ARMED:         if (fire) state_d = (post_rem_new == '0) ? ST_DONE : ST_POST;
                ST_POST:          if (post_last) state_d = ST_DONE;
                default:          state_d = ST_IDLE;
            endcase
        end
    end

    always_comb begin
        capture_busy = 1'b0;
        capture_done = 1'b0;
        case (state_q)
            ST_PRE, ST_ARMED, ST_POST: capture_busy = 1'b1;
            ST_DONE:                   capture_done = 1'b1;
            default:                   ;
        endcase
    end

    always_comb begin
        waddr_d      = waddr_q;
        pre_cnt_d    = pre_cnt_q;
        post_rem_d   = post_rem_q;
        max_addr_d   = max_addr_q;
        pre_eff_d    = pre_eff_q;
        mode_d       = mode_q;
        prev_match_d = prev_match_q;
        if (start_ok) begin
            waddr_d      = '0;
            pre_cnt_d    = '0;
            max_addr_d   = bus.capture_max_addr;
            pre_eff_d    = pre_eff_new;
            mode_d       = bus.capture_mode;
            prev_match_d = '1;
        end else if (sample_ok) begin
            waddr_d      = (waddr_q == max_addr_q) ? '0 : waddr_q + ONE_A;
            prev_match_d = ch_match;
            if (state_q == ST_PRE)  pre_cnt_d  = pre_cnt_inc;
            if (state_q == ST_POST) post_rem_d = post_rem_q - ONE_A;
            if (fire)               post_rem_d = post_rem_new;
        end
    end

    always_comb begin
        ram_wr_en_d   = sample_ok;
        ram_waddr_d   = sample_ok ? waddr_q : ram_waddr_q;
        ram_wdata_d   = sample_ok ? bus.adc_data : ram_wdata_q;
        tri_succeed_d = fire;
        tri_addr_d    = fire ? waddr_q : tri_addr_q;
        read_start_d  = fire ? read_start_new : read_start_q;
        cnt_d         = cnt_q;
        if (bus.tri_succeed_cnt_clr) begin
            cnt_d = '0;
        end else if (fire) begin
            if (cnt_q == '1) cnt_d = bus.tri_succeed_cnt_overflow_mode ? '0 : cnt_q;
            else             cnt_d = cnt_q + ONE_C;
        end
    end

    always_ff @(posedge wr_clk) begin
        if (!wr_rst_n) begin
            waddr_q       <= '0;
            pre_cnt_q     <= '0;
            post_rem_q    <= '0;
            max_addr_q    <= '0;
            pre_eff_q     <= '0;
            mode_q        <= '0;
            prev_match_q  <= '0;
            ram_wr_en_q   <= 1'b0;
            ram_waddr_q   <= '0;
            ram_wdata_q   <= '0;
            tri_succeed_q <= 1'b0;
            tri_addr_q    <= '0;
            read_start_q  <= '0;
            cnt_q         <= '0;
        end else begin
            waddr_q       <= waddr_d;
            pre_cnt_q     <= pre_cnt_d;
            post_rem_q    <= post_rem_d;
            max_addr_q    <= max_addr_d;
            pre_eff_q     <= pre_eff_d;
            mode_q        <= mode_d;
            prev_match_q  <= prev_match_d;
            ram_wr_en_q   <= ram_wr_en_d;
            ram_waddr_q   <= ram_waddr_d;
            ram_wdata_q   <= ram_wdata_d;
            tri_succeed_q <= tri_succeed_d;
            tri_addr_q    <= tri_addr_d;
            read_start_q  <= read_start_d;
            cnt_q         <= cnt_d;
        end
    end

    assign bus.ram_wr_en       = ram_wr_en_q;
    assign bus.ram_waddr       = ram_waddr_q;
    assign bus.ram_wdata       = ram_wdata_q;
    assign bus.tri_succeed     = tri_succeed_q;
    assign bus.tri_addr        = tri_addr_q;
    assign bus.read_start_addr = read_start_q;
    assign bus.capture_busy    = capture_busy;
    assign bus.capture_done    = capture_done;
    assign bus.tri_succeed_cnt = cnt_q;
endmodule
